mips_multicycle_ctrl: RTL and testbench

Control FSM for the multicycle MIPS datapath. It is the block that drives the ALU's 3-bit alucontrol and consumes its zero flag. It sequences each instruction through fetch/decode/execute/memory/writeback states. It emits Moore-decoded datapath controls plus a combinational PC enable that uses zero for branches.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 73 +++++++
 rtl/mips_multicycle_ctrl_if.sv | 29 ++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 29 ++
 rtl/mips_multicycle_ctrl.sv | 72 +++++++
 tb/tb_mips_multicycle_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_BNE
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       bne;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore output decode: everything not listed for a state stays 0 / add.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c       = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BRANCH:  begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_BNE:     begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.bne = 1'b1; end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: aluop + funct -> 3-bit alucontrol (purely combinational).
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Unknown funct codes fall back to add; the writeback still happens.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Outputs are registered alongside the state
// (decoded from the next state), so they are glitch-free Moore signals.
// Optional bne support: define MIPS_CTRL_BNE_EN.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  state_t     state, state_n;
  ctrl_t      ctl;
  logic [2:0] alucontrol;

  // Next-state decode; op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_EXECUTE;
          OP_BEQ:       state_n = S_BRANCH;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_n = S_BNE;
`endif
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEMADR:  state_n = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_n = S_MEMWB;
      S_EXECUTE: state_n = S_ALUWB;
      S_ADDIEX:  state_n = S_ADDIWB;
      default:   state_n = S_FETCH;
    endcase
  end

  // State and registered control word; reset parks everything in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      ctl   <= state_ctrl(S_FETCH);
    end else begin
      state <= state_n;
      ctl   <= state_ctrl(state_n);
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctl.aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol)
  );

  // Write strobes are masked by reset so an abandoned instruction has no effect.
  assign bus.pcen       = ~reset & (ctl.pcwrite | (ctl.branch & bus.zero) | (ctl.bne & ~bus.zero));
  assign bus.irwrite    = ~reset & ctl.irwrite;
  assign bus.memwrite   = ~reset & ctl.memwrite;
  assign bus.regwrite   = ~reset & ctl.regwrite;
  assign bus.iord       = ctl.iord;
  assign bus.regdst     = ctl.regdst;
  assign bus.memtoreg   = ctl.memtoreg;
  assign bus.alusrca    = ctl.alusrca;
  assign bus.alusrcb    = ctl.alusrcb;
  assign bus.pcsrc      = ctl.pcsrc;
  assign bus.alucontrol = alucontrol;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction-level reference
// model (per-instruction cycle tables), directed cases plus random programs.
module tb_mips_multicycle_ctrl;

`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol}
  function automatic logic [14:0] obs_vec();
    return {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol};
  endfunction

  function automatic int lat(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      6'b000101: return BNE_EN ? 3 : 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle k of instruction (o,f) with ALU zero flag z.
  function automatic logic [14:0] ref_out(input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input int k, input logic rst);
    logic pcen, iord, mw, ir, rd, mtr, rw, srca;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluc;
    pcen = 0; iord = 0; mw = 0; ir = 0; rd = 0; mtr = 0; rw = 0; srca = 0;
    srcb = 2'b00; pcsrc = 2'b00; aluc = 3'b010;
    if (rst || k == 0) begin
      srcb = 2'b01; ir = !rst; pcen = !rst;
    end else if (k == 1) begin
      srcb = 2'b11;
    end else begin
      case (o)
        6'b100011, 6'b101011: begin
          if (k == 2) begin srca = 1; srcb = 2'b10; end
          else if (k == 3) begin iord = 1; mw = (o == 6'b101011); end
          else begin mtr = 1; rw = 1; end
        end
        6'b000000: begin
          if (k == 2) begin srca = 1; aluc = funct_alu(f); end
          else begin rd = 1; rw = 1; end
        end
        6'b000100: begin srca = 1; aluc = 3'b110; pcsrc = 2'b01; pcen = z; end
        6'b000101: begin srca = 1; aluc = 3'b110; pcsrc = 2'b01; pcen = !z; end
        6'b001000: begin
          if (k == 2) begin srca = 1; srcb = 2'b10; end
          else rw = 1;
        end
        6'b000010: begin pcsrc = 2'b10; pcen = 1; end
        default: ;
      endcase
    end
    return {pcen, iord, mw, ir, rd, mtr, rw, srca, srcb, pcsrc, aluc};
  endfunction

  task automatic check(input string tag, input logic [14:0] e);
    logic [14:0] o;
    o = obs_vec();
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Runs one instruction from FETCH; entered and left at a falling edge.
  // zmode: 0/1 fixed zero, 2 random each cycle. nsteps < 0 runs to completion.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input int nsteps);
    int   n;
    logic z;
    n = lat(o);
    if (nsteps >= 0 && nsteps < n) n = nsteps;
    for (int k = 0; k < n; k++) begin
      z = (zmode == 2) ? 1'($urandom % 2) : (zmode == 1);
      bus.zero = z;
      if (k == 0) begin
        bus.op = o; bus.funct = f;
      end else if (k >= 3) begin
        bus.op = 6'($urandom); bus.funct = 6'($urandom);
      end
      #1 check($sformatf("op%b_f%b_k%0d", o, f, k), ref_out(o, f, z, k, 1'b0));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Abandon an instruction at cycle kstop with an asynchronous reset.
  task automatic reset_mid(input logic [5:0] o, input logic [5:0] f, input int kstop);
    logic z;
    run_instr(o, f, 2, kstop);
    bus.zero = 1'b1;
    #1 check($sformatf("pre_rst_op%b_k%0d", o, kstop), ref_out(o, f, 1'b1, kstop, 1'b0));
    #1 reset = 1'b1;
    #1 check($sformatf("rst_async_op%b", o), ref_out(o, f, 1'b1, 0, 1'b1));
    @(posedge clk);
    @(negedge clk);
    z = 1'($urandom % 2);
    bus.zero = z;
    #1 check($sformatf("rst_hold_op%b", o), ref_out(o, f, z, 0, 1'b1));
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] fns [6];
    logic [5:0] o, f;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
            6'b000010, 6'b000101, 6'b111111, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    #1 check("reset_state", ref_out(6'd0, 6'd0, 1'b1, 0, 1'b1));
    @(negedge clk);
    reset = 1'b0;

    // Directed: lw, sw, R-type funct sweep, beq both ways, addi, j, illegal, bne.
    run_instr(6'b100011, 6'b000000, 2, -1);
    run_instr(6'b101011, 6'b000000, 2, -1);
    for (int i = 0; i < 6; i++) run_instr(6'b000000, fns[i], 2, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b001000, 6'b000000, 2, -1);
    run_instr(6'b000010, 6'b000000, 2, -1);
    run_instr(6'b111111, 6'b000000, 2, -1);
    run_instr(6'b000101, 6'b000000, 0, -1);
    run_instr(6'b000101, 6'b000000, 1, -1);

    // Reset in EXECUTE, in MEMWB (regwrite high) and in MEMWR (memwrite high).
    reset_mid(6'b000000, 6'b100010, 2);
    run_instr(6'b100011, 6'b000000, 2, -1);
    reset_mid(6'b100011, 6'b000000, 4);
    run_instr(6'b000010, 6'b000000, 2, -1);
    reset_mid(6'b101011, 6'b000000, 3);

    // Random instruction stream.
    repeat (120) begin
      o = ($urandom % 10 == 0) ? 6'($urandom) : ops[$urandom % 9];
      f = ($urandom % 6 == 0) ? 6'($urandom) : fns[$urandom % 6];
      run_instr(o, f, 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
